// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signal bundle: request/lock inputs, muxed bus status,
// and the grant/ownership outputs. The arbiter connects through the master
// modport because it drives the grant side; the fabric uses the slave modport.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_MST = 4
) ();
  logic [NUM_MST-1:0] hbusreq;
  logic [NUM_MST-1:0] hlock;
  logic [1:0]         htrans;
  logic [2:0]         hburst;
  logic               hready;
  logic [1:0]         hresp;
  logic [NUM_MST-1:0] hsplit;
  logic [NUM_MST-1:0] hgrant;
  logic [3:0]         hmaster;
  logic [3:0]         hmaster_d;
  logic               hmastlock;
  logic [NUM_MST-1:0] split_mask;

  modport master (
    input  hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
    output hgrant, hmaster, hmaster_d, hmastlock, split_mask
  );

  modport slave (
    output hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
    input  hgrant, hmaster, hmaster_d, hmastlock, split_mask
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB 2.0 round-robin bus arbiter. Grants only at burst/lock boundaries or on
// a SPLIT response, masks split masters until their HSPLIT release, and tracks
// address- and data-phase ownership.
module ahb_arbiter #(
  parameter int unsigned NUM_MST     = 4,
  parameter int unsigned DEFAULT_MST = 0
) (
  input logic           i_hclk,
  input logic           i_hreset_n,
  ahb_arbiter_if.master bus
);
  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransBusy   = 2'd1;
  localparam logic [1:0] TransNonseq = 2'd2;
  localparam logic [1:0] TransSeq    = 2'd3;
  localparam logic [2:0] BurstIncr   = 3'd1;
  localparam logic [1:0] RespSplit   = 2'd3;

  localparam logic [3:0]         DefIdx   = 4'(DEFAULT_MST);
  localparam logic [NUM_MST-1:0] DefGrant = {{(NUM_MST-1){1'b0}}, 1'b1} << DEFAULT_MST;

  logic [NUM_MST-1:0] grant_q;
  logic [3:0]         hmaster_q;
  logic [3:0]         hmaster_d_q;
  logic               hmastlock_q;
  logic [NUM_MST-1:0] mask_q;
  logic [4:0]         rem_q;
  logic [3:0]         ptr_q;

  logic [4:0]         burst_len;
  logic [15:0]        hlock_pad;
  logic               arb_ok;
  logic               split_pt;
  logic [15:0]        split_set;
  logic [NUM_MST-1:0] mask_next;
  logic [15:0]        eligible_pad;
  logic [3:0]         winner;
  logic               found;
  logic [4:0]         cand;
  logic [15:0]        winner_oh;
  logic [3:0]         grant_idx;

  // Burst length implied by HBURST; SINGLE and undefined-length INCR count as 1.
  always_comb begin
    case (bus.hburst)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd1;
    endcase
  end

  assign hlock_pad = 16'(bus.hlock);
  assign split_pt  = !bus.hready && (bus.hresp == RespSplit);

  // Arbitration point: transfer boundary with no lock held or requested.
  always_comb begin
    arb_ok = bus.hready && !(hmastlock_q || hlock_pad[hmaster_q]) &&
             ((bus.htrans == TransIdle) ||
              ((bus.htrans == TransNonseq) && (burst_len == 5'd1)) ||
              ((bus.htrans == TransSeq) && (rem_q == 5'd1)) ||
              ((bus.hburst == BurstIncr) && (bus.htrans != TransBusy)));
  end

  // Next split mask; a set from this cycle's SPLIT overrides a same-bit release.
  always_comb begin
    split_set = '0;
    if (split_pt) split_set[hmaster_d_q] = 1'b1;
    mask_next = (mask_q & ~bus.hsplit) | split_set[NUM_MST-1:0];
  end

  // Round-robin search starting one past the pointer, falling back to the default master.
  always_comb begin
    eligible_pad = 16'(bus.hbusreq & ~mask_next);
    winner       = DefIdx;
    found        = 1'b0;
    cand         = '0;
    for (int k = 1; k <= int'(NUM_MST); k++) begin
      cand = 5'(ptr_q) + 5'(k);
      if (cand >= 5'(NUM_MST)) cand = cand - 5'(NUM_MST);
      if (!found && eligible_pad[cand[3:0]]) begin
        found  = 1'b1;
        winner = cand[3:0];
      end
    end
    winner_oh = 16'b1 << winner;
  end

  // Index of the currently granted master.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (grant_q[i]) grant_idx = 4'(i);
    end
  end

  // Remaining-beat counter for fixed-length bursts.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      rem_q <= '0;
    end else if (bus.hready) begin
      if (bus.htrans == TransNonseq) begin
        rem_q <= burst_len - 5'd1;
      end else if ((bus.htrans == TransSeq) && (rem_q != 5'd0)) begin
        rem_q <= rem_q - 5'd1;
      end
    end
  end

  // Grant and round-robin pointer; pointer only moves on a genuine winner.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      grant_q <= DefGrant;
      ptr_q   <= DefIdx;
    end else if (arb_ok || split_pt) begin
      grant_q <= winner_oh[NUM_MST-1:0];
      if (found) ptr_q <= winner;
    end
  end

  // Address/data-phase ownership follows the grant one HREADY later.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      hmaster_q   <= DefIdx;
      hmaster_d_q <= DefIdx;
      hmastlock_q <= 1'b0;
    end else if (bus.hready) begin
      hmaster_q   <= grant_idx;
      hmaster_d_q <= hmaster_q;
      hmastlock_q <= hlock_pad[grant_idx];
    end
  end

  // Split mask register.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_next;
    end
  end

  assign bus.hgrant     = grant_q;
  assign bus.hmaster    = hmaster_q;
  assign bus.hmaster_d  = hmaster_d_q;
  assign bus.hmastlock  = hmastlock_q;
  assign bus.split_mask = mask_q;
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- AHB 2.0 bus arbiter for the FreeAHB fabric.
- Shares one AHB address/data bus between up to 16 ahb_master instances: samples their bus requests and lock requests, and drives one-hot grants.
- Produces HMASTER (address-phase owner), the data-phase owner and HMASTLOCK for slaves and the decoder/mux.
- Round-robin arbitration; fixed-length bursts and locked sequences are never broken; SPLIT masking and HSPLIT release are supported.

Parameters:
- NUM_MST, 4, number of masters (2..16).
- DEFAULT_MST, 0, master granted when no eligible request exists; also the reset owner.

Ports:
- i_hclk  in  1  AHB clock; all state on rising edge.
- i_hreset_n  in  1  asynchronous active-low reset.
- i_hbusreq  in  NUM_MST  bus request per master.
- i_hlock  in  NUM_MST  locked-transfer request per master.
- i_htrans  in  2  HTRANS of current address-phase owner (muxed bus).
- i_hburst  in  3  HBURST of current address-phase owner.
- i_hready  in  1  HREADY from slave mux.
- i_hresp  in  2  HRESP from slave mux.
- i_hsplit  in  NUM_MST  split-release bits, OR of all split-capable slaves.
- o_hgrant  out  NUM_MST  one-hot grant, registered.
- o_hmaster  out  4  address-phase owner index.
- o_hmaster_d  out  4  data-phase owner index.
- o_hmastlock  out  1  current address phase is locked.
- o_split_mask  out  NUM_MST  masters currently split-masked (status).

Behaviour:
- Reset:
  - o_hgrant = one-hot(DEFAULT_MST); o_hmaster = o_hmaster_d = DEFAULT_MST; o_hmastlock = 0.
  - o_split_mask = 0; beat counter rem = 0; RR pointer = DEFAULT_MST.
  - Reset mid-transfer aborts everything immediately.
- Beat counter rem (5 bits), updated only when i_hready=1:
  - htrans=NONSEQ: rem <= len-1, where len is 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, and 1 for SINGLE/INCR.
  - htrans=SEQ: rem <= rem-1, saturating at 0.
  - IDLE/BUSY: hold.
- Arbitration point (arb_ok), all of:
  - i_hready=1;
  - !(o_hmastlock || i_hlock[o_hmaster]);
  - any of: htrans=IDLE; htrans=NONSEQ with len=1; htrans=SEQ with rem=1; hburst=INCR and htrans≠BUSY.
  - BUSY inside a fixed burst is never an arbitration point.
- Split point: i_hready=0 and i_hresp=SPLIT (first response cycle). Forces re-arbitration at the next edge regardless of lock/burst state. RETRY and ERROR do not change grant or mask.
- Selection, evaluated on arb_ok or split point:
  - Eligible = i_hbusreq & ~mask_next, where mask_next is the mask after this cycle's set/clear.
  - Winner = first eligible index scanning (ptr+1) mod NUM_MST upward, wrapping.
  - No eligible master: winner = DEFAULT_MST, even if masked; the default master drives IDLE when not requesting.
  - o_hgrant <= one-hot(winner); ptr <= winner only if the winner was eligible.
  - Otherwise o_hgrant holds.
- Ownership, on i_hready=1:
  - o_hmaster <= index(o_hgrant); o_hmaster_d <= o_hmaster; o_hmastlock <= i_hlock[index(o_hgrant)].
  - Grant-to-ownership latency: 1 cycle after hready. i_hready=0 freezes all three.
- Split mask:
  - Split point sets mask[o_hmaster_d].
  - i_hsplit[i]=1 clears mask[i].
  - Set and clear on the same bit in the same cycle: set wins.
  - Bits at index ≥ NUM_MST are ignored.
- Single requester: it keeps the grant continuously, with no dead cycles.
- Grant removal mid-INCR is legal; the master drops to IDLE/NONSEQ per its own logic.

Test Plan:
- Reset, no requests → o_hgrant=0001, o_hmaster=0; then req=0010 with htrans=IDLE, hready=1 → grant 0010 next edge, o_hmaster=1 one hready later.
- Masters 1 and 2 request with master 1 owning an INCR4 (NONSEQ, SEQ×3, hready=1) → grant stays 0010 until the cycle of the 3rd SEQ (rem=1), then becomes 0100.
- All four request continuously, IDLE/SINGLE traffic → grants rotate 1,2,3,0,1… one change per arbitration point; hready=0 for 3 cycles freezes o_hmaster/o_hmaster_d.
- Master 2 with i_hlock=1 doing INCR while master 3 requests → grant held at 0100 until i_hlock drops and o_hmastlock=0; o_hmastlock=1 during locked phases.
- Data-phase owner 1 receives SPLIT (hready=0, hresp=SPLIT) → o_split_mask=0010, master 1 not granted despite request; i_hsplit=0010 pulse → mask cleared, master 1 eligible at the next arbitration point; simultaneous set+clear of bit 1 → mask stays 1.
- Only requester masked, DEFAULT_MST=0 → grant 0001, ptr unchanged; assert reset during an INCR8 → all outputs return to reset values asynchronously.
